// File: rtl/rv32_mtimer_pkg.sv
// Shared types for the machine timer: register offsets, bus FSM states, CTRL layout.
`default_nettype none

package rv32_types;

  localparam int          MTIMER_PRESCALE_W = 16;
  localparam logic [31:0] MTIMER_BASE       = 32'h0200_4000;

  typedef enum logic [2:0] {
    MTIMER_MTIME_LO = 3'd0,
    MTIMER_MTIME_HI = 3'd1,
    MTIMER_CMP_LO   = 3'd2,
    MTIMER_CMP_HI   = 3'd3,
    MTIMER_CTRL     = 3'd4
  } mtimer_reg_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } mtimer_bus_e;

  typedef struct packed {
    logic [MTIMER_PRESCALE_W-1:0] divisor;
    logic                         enable;
  } mtimer_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/rv32_mtimer_prescaler.sv
// Prescaler: emits a one-cycle tick every (divisor+1) enabled cycles.
`default_nettype none

module rv32_mtimer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] divisor,
  input  logic                  clear,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt;

  assign tick = enable && (cnt == divisor);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv32_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp, mtip generation and a single-outstanding word bus port.
`default_nettype none

module rv32_mtimer
  import rv32_types::*;
#(
  parameter int          PRESCALE_W     = 16,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [4:0]  req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        mtip
);

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged_word;
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged_word[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged_word;
  endfunction

  mtimer_bus_e  state;
  mtimer_reg_e  sel;
  mtimer_ctrl_t ctrl;
  logic [63:0]  mtime;
  logic [63:0]  mtimecmp;
  logic [31:0]  shadow;
  logic [31:0]  rd_hold;
  logic [31:0]  ctrl_word;
  logic [31:0]  cur_word;
  logic [31:0]  rd_value;
  logic [31:0]  merged;
  logic         accept;
  logic         wr;
  logic         tick;
  logic         unused_addr;

  // Byte lanes are selected by req_be, so the low address bits carry no information.
  assign unused_addr = ^req_addr[1:0];

  assign sel       = mtimer_reg_e'(req_addr[4:2]);
  assign accept    = (state == BUS_IDLE) && req_valid;
  assign wr        = accept && req_we;
  assign ctrl_word = (32'(ctrl.divisor[PRESCALE_W-1:0]) << 8) | {31'd0, ctrl.enable};

  always_comb begin
    cur_word = '0;
    case (sel)
      MTIMER_MTIME_LO: cur_word = mtime[31:0];
      MTIMER_MTIME_HI: cur_word = mtime[63:32];
      MTIMER_CMP_LO:   cur_word = mtimecmp[31:0];
      MTIMER_CMP_HI:   cur_word = mtimecmp[63:32];
      MTIMER_CTRL:     cur_word = ctrl_word;
      default:         cur_word = '0;
    endcase
  end

  assign rd_value = (sel == MTIMER_MTIME_HI) ? shadow : cur_word;
  assign merged   = be_merge(cur_word, req_wdata, req_be);

  rv32_mtimer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .resetn  (resetn),
    .enable  (ctrl.enable),
    .divisor (ctrl.divisor[PRESCALE_W-1:0]),
    .clear   (wr && (sel == MTIMER_CTRL)),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mtime        <= '0;
      mtimecmp     <= MTIMECMP_RESET;
      ctrl.enable  <= 1'b1;
      ctrl.divisor <= '0;
      shadow       <= '0;
      mtip         <= 1'b0;
    end else begin
      mtip <= (mtime >= mtimecmp);

      // A software write to either half overrides the tick, so no carry crosses halves.
      if (wr && (sel == MTIMER_MTIME_LO)) begin
        mtime[31:0] <= merged;
      end else if (wr && (sel == MTIMER_MTIME_HI)) begin
        mtime[63:32] <= merged;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (wr && (sel == MTIMER_CMP_LO)) mtimecmp[31:0]  <= merged;
      if (wr && (sel == MTIMER_CMP_HI)) mtimecmp[63:32] <= merged;

      if (wr && (sel == MTIMER_CTRL)) begin
        ctrl.enable  <= merged[0];
        ctrl.divisor <= MTIMER_PRESCALE_W'(merged[8 +: PRESCALE_W]);
      end

      if (accept && !req_we && (sel == MTIMER_MTIME_LO)) shadow <= mtime[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= BUS_IDLE;
      done    <= 1'b0;
      rdata   <= '0;
      rd_hold <= '0;
    end else begin
      case (state)
        BUS_IDLE: begin
          done  <= 1'b0;
          rdata <= '0;
          if (req_valid) begin
            state   <= BUS_RESP;
            rd_hold <= req_we ? 32'd0 : rd_value;
          end
        end
        BUS_RESP: begin
          state <= BUS_IDLE;
          done  <= 1'b1;
          rdata <= rd_hold;
        end
        default: state <= BUS_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
